// File: rtl/alu_pkg.sv
// Opcodes, request legality and scheduler state shared by the ALU scheduler
// and anything that needs to decode ALUSRC the same way.
package alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_ANN   = 3'b100;
  localparam logic [2:0] OP_WLOAD = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } sched_state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= OP_WLOAD;
  endfunction

  // An ANN op is only meaningful once the ALU holds weights.
  function automatic logic is_err_req(input logic [2:0] op, input logic weights_loaded);
    return !is_legal_op(op) || ((op == OP_ANN) && !weights_loaded);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the port
// that did not win last time. History only advances when enabled.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_q;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Reset to port 1 so that port 0 takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (en && (|req)) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one ALU between the integer pipe (port 0) and the ANN pipe (port 1):
// arbitrate, drive the ALU for RESULT_LAT cycles, return the result over valid/ready.
module alu_sched
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RESULT_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [2:0]         req0_op,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [WIDTH-1:0]   req0_c,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [2:0]         req1_op,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  input  logic [WIDTH-1:0]   req1_c,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic [WIDTH-1:0]   rsp0_data,
  output logic               rsp0_err,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [WIDTH-1:0]   rsp1_data,
  output logic               rsp1_err,
  output logic [2:0]         alu_src,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [WIDTH-1:0]   alu_c,
  input  logic [WIDTH-1:0]   alu_y,
  output logic               weights_loaded,
  output sched_state_t       dbg_state
);

  // Handshake: a request transfers on a cycle where reqN_valid && reqN_ready,
  // a response on a cycle where rspN_valid && rspN_ready. Ready may depend on
  // valid; valid must never depend on ready. Payloads hold while valid is up.

  localparam logic [2:0] CNT_INIT = 3'(RESULT_LAT - 1);

  sched_state_t     state_q;
  logic [2:0]       cnt_q;
  logic             gidx_q;
  logic [2:0]       op_q;
  logic [2:0]       alu_src_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [WIDTH-1:0] alu_c_q;
  logic [1:0]       rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;
  logic             weights_q;

  logic [1:0]       req_valid;
  logic [1:0]       rsp_ready;
  logic [1:0]       gnt;
  logic             idle;
  logic             accept;
  logic             rsp_done;
  logic             gidx_d;
  logic [2:0]       op_d;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] c_d;
  logic             err_d;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign idle      = (state_q == S_IDLE);

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .en  (idle),
    .gnt (gnt)
  );

  assign accept   = idle && (|gnt);
  assign gidx_d   = gnt[1];
  assign rsp_done = |(rsp_valid_q & rsp_ready);

  always_comb begin
    if (gidx_d) begin
      op_d = req1_op;
      a_d  = req1_a;
      b_d  = req1_b;
      c_d  = req1_c;
    end else begin
      op_d = req0_op;
      a_d  = req0_a;
      b_d  = req0_b;
      c_d  = req0_c;
    end
  end

  assign err_d = is_err_req(op_d, weights_q);

  // Error requests skip EXEC so the ALU never sees an illegal or premature op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      gidx_q      <= 1'b0;
      op_q        <= OP_ADD;
      alu_src_q   <= OP_ADD;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_c_q     <= '0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      weights_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            gidx_q <= gidx_d;
            op_q   <= op_d;
            if (err_d) begin
              rsp_valid_q <= gidx_d ? 2'b10 : 2'b01;
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              alu_src_q <= op_d;
              alu_a_q   <= a_d;
              alu_b_q   <= b_d;
              alu_c_q   <= c_d;
              cnt_q     <= CNT_INIT;
              state_q   <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (cnt_q == 3'd0) begin
            rsp_valid_q <= gidx_q ? 2'b10 : 2'b01;
            rsp_data_q  <= alu_y;
            rsp_err_q   <= 1'b0;
            if (op_q == OP_WLOAD) begin
              weights_q <= 1'b1;
            end
            alu_src_q <= OP_ADD;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_c_q   <= '0;
            state_q   <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_RESP: begin
          if (rsp_done) begin
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req0_ready = idle && gnt[0];
  assign req1_ready = idle && gnt[1];

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_data  = rsp_valid_q[0] ? rsp_data_q : '0;
  assign rsp1_data  = rsp_valid_q[1] ? rsp_data_q : '0;
  assign rsp0_err   = rsp_valid_q[0] & rsp_err_q;
  assign rsp1_err   = rsp_valid_q[1] & rsp_err_q;

  assign alu_src = alu_src_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_c   = alu_c_q;

  assign weights_loaded = weights_q;
  assign dbg_state      = state_q;

  a_rsp_onehot: assert property (@(posedge clk) disable iff (rst)
    !(rsp_valid_q[0] && rsp_valid_q[1]));

  // WLOAD rewrites ALU-internal weights, so it may only appear while executing one.
  a_wload_contained: assert property (@(posedge clk) disable iff (rst)
    (alu_src_q == OP_WLOAD) |-> ((state_q == S_EXEC) && (op_q == OP_WLOAD)));

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: behavioural ALU on the ALU bus, per-port expected queues
// predicted from the opcode rules, directed scenarios plus a random tail.
module tb_alu_sched;
  import alu_pkg::*;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]     req0_op, req1_op;
  logic [W-1:0]   req0_a, req0_b, req0_c, req1_a, req1_b, req1_c;
  logic           rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
  logic [W-1:0]   rsp0_data, rsp1_data;
  logic [2:0]     alu_src;
  logic [W-1:0]   alu_a, alu_b, alu_c, alu_y;
  logic           weights_loaded;
  sched_state_t   dbg_state;

  int             checks = 0;
  int             failures = 0;
  logic [W:0]     exp_q0[$];
  logic [W:0]     exp_q1[$];
  logic [W:0]     mon_e;
  logic           m_wl = 1'b0;
  logic [W-1:0]   m_w = '0;
  logic [W-1:0]   alu_w = '0;
  logic           saw_ann = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  alu_sched #(.WIDTH(W), .RESULT_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .alu_src(alu_src), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_y(alu_y),
    .weights_loaded(weights_loaded), .dbg_state(dbg_state)
  );

  // ---------------- ALU behaviour (environment) ----------------
  function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] c,
                                          input logic [W-1:0] w);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a * w + b + c;
      3'd5:    return a ^ b ^ c;
      default: return '0;
    endcase
  endfunction

  assign alu_y = alu_fn(alu_src, alu_a, alu_b, alu_c, alu_w);

  always @(posedge clk) if (alu_src == OP_WLOAD) alu_w <= alu_a;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Expected response from the opcode rules and the scheduler-wide weight state.
  task automatic push_exp(input int port, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] c);
    logic [W:0] e;
    if (op > 3'd5 || (op == 3'd4 && !m_wl)) e = {1'b1, {W{1'b0}}};
    else e = {1'b0, alu_fn(op, a, b, c, m_w)};
    if (op == 3'd5) begin
      m_wl = 1'b1;
      m_w  = a;
    end
    if (port == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  // Scoreboard: every response handshake pops and compares.
  always @(negedge clk) begin
    if (!rst) begin
      if (alu_src == OP_ANN) saw_ann = 1'b1;
      if (rsp0_valid || rsp1_valid) chk1("rsp_onehot", rsp0_valid && rsp1_valid, 1'b0);
      if (rsp0_valid && rsp0_ready) begin
        if (exp_q0.size() == 0) chk1("rsp0_unexpected", rsp0_valid, 1'b0);
        else begin
          mon_e = exp_q0.pop_front();
          chk("rsp0_data", rsp0_data, mon_e[W-1:0]);
          chk1("rsp0_err", rsp0_err, mon_e[W]);
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        if (exp_q1.size() == 0) chk1("rsp1_unexpected", rsp1_valid, 1'b0);
        else begin
          mon_e = exp_q1.pop_front();
          chk("rsp1_data", rsp1_data, mon_e[W-1:0]);
          chk1("rsp1_err", rsp1_err, mon_e[W]);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input int port, input logic v, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    if (port == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_c = c;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_c = c;
    end
  endtask

  // Returns just after the accepting edge (cycle T+1 has begun).
  task automatic issue(input int port, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] c);
    int n = 0;
    drive(port, 1'b1, op, a, b, c);
    #1;
    while (!(port == 0 ? req0_ready : req1_ready) && n < 64) begin
      @(negedge clk); #1; n++;
    end
    chk1("issue_ready", n < 64, 1'b1);
    if (n < 64) begin
      push_exp(port, op, a, b, c);
      @(posedge clk); #1;
    end
    drive(port, 1'b0, op, a, b, c);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 64) begin
      @(negedge clk); n++;
    end
    chk1("drain", n < 64, 1'b1);
    @(negedge clk);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [W-1:0] ra, rb, rc, rd, save_w;
    int           w, n, port;
    logic [2:0]   op;

    drive(0, 1'b0, OP_ADD, '0, '0, '0);
    drive(1, 1'b0, OP_ADD, '0, '0, '0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk1("rst_req0_ready", req0_ready, 1'b0);
    chk1("rst_req1_ready", req1_ready, 1'b0);
    chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk("rst_rsp0_data", rsp0_data, '0);
    chk1("rst_rsp1_err", rsp1_err, 1'b0);
    chk("rst_alu_src", W'(alu_src), '0);
    chk("rst_alu_abc", alu_a | alu_b | alu_c, '0);
    chk1("rst_weights", weights_loaded, 1'b0);
    chk("rst_state", W'(dbg_state), W'(S_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Single ADD on port 0: ALU driven one cycle, response at T+2
    issue(0, OP_ADD, 32'd3, 32'd3, 32'd0);
    @(negedge clk);
    chk("add_t1_src", W'(alu_src), W'(OP_ADD));
    chk("add_t1_a", alu_a, 32'd3);
    chk("add_t1_b", alu_b, 32'd3);
    chk1("add_t1_rsp0_valid", rsp0_valid, 1'b0);
    @(negedge clk);
    chk1("add_t2_rsp0_valid", rsp0_valid, 1'b1);
    chk("add_t2_data", rsp0_data, 32'd6);
    chk1("add_t2_err", rsp0_err, 1'b0);
    chk1("add_t2_rsp1_valid", rsp1_valid, 1'b0);
    chk("add_t2_alu_idle", alu_a, '0);
    @(negedge clk);
    chk1("add_t3_rsp0_valid", rsp0_valid, 1'b0);

    // ANN before any WLOAD is rejected without touching the ALU
    saw_ann = 1'b0;
    issue(1, OP_ANN, $urandom, $urandom, $urandom);
    @(negedge clk);
    chk1("ann_early_valid", rsp1_valid, 1'b1);
    chk1("ann_early_err", rsp1_err, 1'b1);
    chk("ann_early_data", rsp1_data, '0);
    chk("ann_early_src", W'(alu_src), '0);
    wait_idle();
    chk1("ann_early_weights", weights_loaded, 1'b0);
    issue(1, OP_WLOAD, 32'd3, 32'd3, 32'd3);
    @(negedge clk);
    chk("wload_src", W'(alu_src), W'(OP_WLOAD));
    wait_idle();
    chk1("wload_weights", weights_loaded, 1'b1);
    chk1("ann_never_on_alu", saw_ann, 1'b0);
    // WLOAD from port 1 enables ANN on port 0
    issue(0, OP_ANN, $urandom, $urandom, $urandom);
    @(negedge clk);
    chk("ann_src", W'(alu_src), W'(OP_ANN));
    wait_idle();

    // Tie: make port 1 the last winner, then hold both valid for four accepts
    issue(1, OP_ADD, $urandom, $urandom, $urandom);
    wait_idle();
    drive(0, 1'b1, OP_SUB, 32'd5, 32'd3, 32'd0);
    drive(1, 1'b1, OP_OR, 32'hF0, 32'h0F, 32'd0);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      #1;
      while (!(req0_ready || req1_ready) && n < 64) begin
        @(negedge clk); #1; n++;
      end
      chk1("tie_ready_seen", n < 64, 1'b1);
      chk1("tie_both_ready", req0_ready && req1_ready, 1'b0);
      w = req1_ready ? 1 : 0;
      chk("tie_order", W'(w), W'(k % 2));
      if (w == 0) push_exp(0, OP_SUB, 32'd5, 32'd3, 32'd0);
      else push_exp(1, OP_OR, 32'hF0, 32'h0F, 32'd0);
      @(posedge clk);
      if (k == 3) begin
        #1;
        drive(0, 1'b0, OP_SUB, 32'd5, 32'd3, 32'd0);
        drive(1, 1'b0, OP_OR, 32'hF0, 32'h0F, 32'd0);
      end
      @(negedge clk);
    end
    wait_idle();

    // Backpressure on port 0 while port 1 waits
    ra = $urandom; rb = $urandom; rc = $urandom; rd = $urandom;
    #1 rsp0_ready = 1'b0;
    issue(0, OP_AND, ra, rb, 32'd0);
    drive(1, 1'b1, OP_ADD, rc, rd, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("bp_rsp0_valid", rsp0_valid, 1'b1);
      chk("bp_rsp0_data", rsp0_data, ra & rb);
      chk1("bp_req1_ready", req1_ready, 1'b0);
      chk("bp_alu_src", W'(alu_src), '0);
    end
    @(posedge clk);
    #1 rsp0_ready = 1'b1;
    issue(1, OP_ADD, rc, rd, 32'd0);
    wait_idle();

    // Illegal opcode: immediate error response, ALU untouched
    issue(0, 3'b111, $urandom, $urandom, $urandom);
    @(negedge clk);
    chk1("ill_valid", rsp0_valid, 1'b1);
    chk1("ill_err", rsp0_err, 1'b1);
    chk("ill_data", rsp0_data, '0);
    chk("ill_src", W'(alu_src), '0);
    wait_idle();

    // Reset during EXEC of a WLOAD
    save_w = m_w;
    issue(0, OP_WLOAD, $urandom, $urandom, $urandom);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_state", W'(dbg_state), W'(S_IDLE));
    chk("mid_rst_alu_src", W'(alu_src), '0);
    chk("mid_rst_alu_a", alu_a, '0);
    chk1("mid_rst_rsp0_valid", rsp0_valid, 1'b0);
    chk1("mid_rst_weights", weights_loaded, 1'b0);
    exp_q0.delete();
    m_wl = 1'b0;
    m_w  = save_w;
    @(negedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("post_rst_no_rsp", rsp0_valid, 1'b0);
    end
    issue(1, OP_ANN, $urandom, $urandom, $urandom);
    wait_idle();
    chk1("post_rst_weights", weights_loaded, 1'b0);
    issue(0, OP_SUB, $urandom, $urandom, $urandom);
    wait_idle();

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      port = $urandom_range(0, 1);
      op   = 3'($urandom_range(0, 7));
      issue(port, op, $urandom, $urandom, $urandom);
      wait_idle();
      chk1("rand_weights", weights_loaded, m_wl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
